// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and helpers for the FFT output reordering path.
// Holds the complex sample type, the frame-size constant and a width-generic bit reversal.
package fft_bitrev_reorder_pkg;

   localparam int PROD_W       = 16;
   localparam int FFT_N        = 64;
   localparam int BITREV_MAX_W = 10;

   typedef struct packed {
      logic signed [PROD_W-1:0] r;
      logic signed [PROD_W-1:0] i;
   } complex_product_t;

   // Reverses the low 'width' bits of x; bits above 'width' come back as zero.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                      input int width);
      logic [BITREV_MAX_W-1:0] y;
      logic [BITREV_MAX_W-1:0] t;
      y = '0;
      t = x;
      for (int b = 0; b < BITREV_MAX_W; b++) begin
         if (b < width) begin
            y = {y[BITREV_MAX_W-2:0], t[0]};
            t = t >> 1;
         end
      end
      return y;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_pingpong_bank_ctrl.sv
// Ping-pong bookkeeping for the reorder buffer: FULL flags, bank pointers and sample counters.
// The writer only ever targets a non-full bank and the reader a full one, so they never collide.
module pingpong_bank_ctrl
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int N = FFT_N
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_wrAccept,
   input  logic                 i_rdLoad,
   output logic                 o_wrBank,
   output logic                 o_rdBank,
   output logic [$clog2(N)-1:0] o_wrCnt,
   output logic [$clog2(N)-1:0] o_rdCnt,
   output logic [1:0]           o_full
);

   localparam int LOG2N = $clog2(N);
   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   logic             r_wrBank;
   logic             r_rdBank;
   logic [LOG2N-1:0] r_wrCnt;
   logic [LOG2N-1:0] r_rdCnt;
   logic [1:0]       r_full;
   logic [1:0]       w_fullNext;
   logic             w_wrDone;
   logic             w_rdDone;

   assign w_wrDone = i_wrAccept && (r_wrCnt == LAST);
   assign w_rdDone = i_rdLoad && (r_rdCnt == LAST);

   always_comb begin
      w_fullNext = r_full;
      if (w_rdDone) w_fullNext[r_rdBank] = 1'b0;
      if (w_wrDone) w_fullNext[r_wrBank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrBank <= 1'b0;
         r_rdBank <= 1'b0;
         r_wrCnt  <= '0;
         r_rdCnt  <= '0;
         r_full   <= '0;
      end else begin
         r_full <= w_fullNext;
         if (i_wrAccept) begin
            r_wrCnt <= w_wrDone ? '0 : r_wrCnt + 1'b1;
            if (w_wrDone) r_wrBank <= ~r_wrBank;
         end
         if (i_rdLoad) begin
            r_rdCnt <= w_rdDone ? '0 : r_rdCnt + 1'b1;
            if (w_rdDone) r_rdBank <= ~r_rdBank;
         end
      end
   end

   assign o_wrBank = r_wrBank;
   assign o_rdBank = r_rdBank;
   assign o_wrCnt  = r_wrCnt;
   assign o_rdCnt  = r_rdCnt;
   assign o_full   = r_full;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed FFT output frames to natural order using two N-entry banks.
// Samples are scattered on write (bit-reversed address) and read back sequentially.
module fft_bitrev_reorder
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int N = FFT_N
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  complex_product_t in_data,
   output logic             in_ready,
   output logic             out_valid,
   output complex_product_t out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             overflow
);

   localparam int LOG2N = $clog2(N);

   complex_product_t r_mem [2][N];
   complex_product_t r_outData;
   logic             r_outValid;
   logic             r_outLast;
   logic             r_overflow;

   logic             w_wrBank;
   logic             w_rdBank;
   logic [LOG2N-1:0] w_wrCnt;
   logic [LOG2N-1:0] w_rdCnt;
   logic [1:0]       w_full;
   logic [LOG2N-1:0] w_wrAddr;
   logic             w_wrAccept;
   logic             w_rdLoad;

   pingpong_bank_ctrl #(.N(N)) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .i_wrAccept (w_wrAccept),
      .i_rdLoad   (w_rdLoad),
      .o_wrBank   (w_wrBank),
      .o_rdBank   (w_rdBank),
      .o_wrCnt    (w_wrCnt),
      .o_rdCnt    (w_rdCnt),
      .o_full     (w_full)
   );

   assign in_ready   = ~w_full[w_wrBank];
   assign w_wrAccept = in_valid && in_ready;
   assign w_rdLoad   = w_full[w_rdBank] && (!r_outValid || out_ready);
   assign w_wrAddr   = LOG2N'(bitrev(BITREV_MAX_W'(w_wrCnt), LOG2N));

   // Storage carries no reset: the FULL flags alone decide what is ever read out.
   always_ff @(posedge clk) begin
      if (w_wrAccept) r_mem[w_wrBank][w_wrAddr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outLast  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_rdLoad) begin
            r_outValid <= 1'b1;
            r_outData  <= r_mem[w_rdBank][w_rdCnt];
            r_outLast  <= (w_rdCnt == LOG2N'(N - 1));
         end else if (out_ready) begin
            r_outValid <= 1'b0;
         end
         if (in_valid && !in_ready) r_overflow <= 1'b1;
      end
   end

   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_last  = r_outLast;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed checks of the bit-reversal reorder buffer at N=8, plus a scoreboarded N=64 random run.
// Inputs change 1 time unit after the rising edge; outputs are observed at the same point.
module tb_fft_bitrev_reorder;
   import fft_bitrev_reorder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset8, inValid8, inReady8, outValid8, outLast8, outReady8, overflow8;
   complex_product_t inData8, outData8;
   logic             reset64, inValid64, inReady64, outValid64, outLast64, outReady64, overflow64;
   complex_product_t inData64, outData64;

   fft_bitrev_reorder #(.N(8)) dut8 (
      .clk(clk), .reset(reset8), .in_valid(inValid8), .in_data(inData8), .in_ready(inReady8),
      .out_valid(outValid8), .out_data(outData8), .out_last(outLast8), .out_ready(outReady8),
      .overflow(overflow8)
   );

   fft_bitrev_reorder #(.N(64)) dut64 (
      .clk(clk), .reset(reset64), .in_valid(inValid64), .in_data(inData64), .in_ready(inReady64),
      .out_valid(outValid64), .out_data(outData64), .out_last(outLast64), .out_ready(outReady64),
      .overflow(overflow64)
   );

   int   nCompared = 0;
   int   nMismatched = 0;
   int   cyc = 0;
   int   gotR[$];
   int   gotI[$];
   logic gotL[$];
   int   gotCyc[$];
   int   lastAccCyc;
   int   droppedWhileBusy;
   int   brev8Tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   function automatic int brevInt(input int x, input int w);
      int r;
      r = 0;
      for (int b = 0; b < w; b++) r = (r * 2) + ((x >> b) & 1);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clearQ();
      gotR.delete();
      gotI.delete();
      gotL.delete();
      gotCyc.delete();
      droppedWhileBusy = 0;
      lastAccCyc = -1;
   endtask

   // One clock of N=8 stimulus; records any transfer/acceptance that the coming edge will perform.
   task automatic cycle8(input logic v, input int k, input logic rdy);
      inValid8   = v;
      inData8.r  = 16'(k);
      inData8.i  = 16'(-k);
      outReady8  = rdy;
      if (outValid8 && outReady8) begin
         gotR.push_back(int'(outData8.r));
         gotI.push_back(int'(outData8.i));
         gotL.push_back(outLast8);
         gotCyc.push_back(cyc);
      end
      if (inValid8 && !inReady8) droppedWhileBusy++;
      if (inValid8 && inReady8) lastAccCyc = cyc + 1;
      step();
   endtask

   task automatic applyReset8();
      reset8    = 1'b1;
      inValid8  = 1'b0;
      outReady8 = 1'b0;
      step();
      step();
      reset8 = 1'b0;
      clearQ();
   endtask

   task automatic test_reset();
      inValid8 = 1'b1;
      applyReset8();
      inValid8 = 1'b0;
      nCompared++;
      if (outValid8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid8); end
      nCompared++;
      if (inReady8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady8); end
      nCompared++;
      if (overflow8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow8); end
      nCompared++;
      if (outLast8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_last got=%b exp=0", outLast8); end
      nCompared++;
      if (outData8 !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_data got=%h exp=0", outData8); end
   endtask

   task automatic test_single_frame();
      applyReset8();
      for (int k = 0; k < 8; k++) cycle8(1'b1, k, 1'b1);
      for (int t = 0; t < 40 && gotR.size() < 8; t++) cycle8(1'b0, 0, 1'b1);
      nCompared++;
      if (gotR.size() !== 8) begin nMismatched++; $display("[TB] FAIL single_count got=%0d exp=8", gotR.size()); end
      for (int m = 0; m < gotR.size() && m < 8; m++) begin
         nCompared++;
         if (gotR[m] !== brev8Tab[m] || gotI[m] !== -brev8Tab[m]) begin
            nMismatched++;
            $display("[TB] FAIL single_data[%0d] got=%0d/%0d exp=%0d/%0d", m, gotR[m], gotI[m], brev8Tab[m], -brev8Tab[m]);
         end
         nCompared++;
         if (gotL[m] !== (m == 7)) begin nMismatched++; $display("[TB] FAIL single_last[%0d] got=%b exp=%b", m, gotL[m], m == 7); end
      end
      if (gotCyc.size() > 0) begin
         nCompared++;
         if (gotCyc[0] !== lastAccCyc + 1) begin
            nMismatched++;
            $display("[TB] FAIL single_latency got=edge%0d exp=edge%0d", gotCyc[0], lastAccCyc + 1);
         end
      end
      nCompared++;
      if (outValid8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_idle_valid got=%b exp=0", outValid8); end
   endtask

   task automatic test_back_to_back();
      applyReset8();
      for (int f = 0; f < 4; f++)
         for (int j = 0; j < 8; j++) cycle8(1'b1, f * 8 + j, 1'b1);
      for (int t = 0; t < 60 && gotR.size() < 32; t++) cycle8(1'b0, 0, 1'b1);
      nCompared++;
      if (droppedWhileBusy !== 0) begin nMismatched++; $display("[TB] FAIL b2b_in_ready_drops got=%0d exp=0", droppedWhileBusy); end
      nCompared++;
      if (overflow8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_overflow got=%b exp=0", overflow8); end
      nCompared++;
      if (gotR.size() !== 32) begin nMismatched++; $display("[TB] FAIL b2b_count got=%0d exp=32", gotR.size()); end
      for (int m = 0; m < gotR.size() && m < 32; m++) begin
         nCompared++;
         if (gotR[m] !== (m / 8) * 8 + brev8Tab[m % 8] || gotL[m] !== (m % 8 == 7)) begin
            nMismatched++;
            $display("[TB] FAIL b2b_data[%0d] got=%0d last=%b exp=%0d last=%b", m, gotR[m], gotL[m],
                     (m / 8) * 8 + brev8Tab[m % 8], m % 8 == 7);
         end
         nCompared++;
         if (gotCyc[m] !== gotCyc[0] + m) begin
            nMismatched++;
            $display("[TB] FAIL b2b_contiguous[%0d] got=edge%0d exp=edge%0d", m, gotCyc[m], gotCyc[0] + m);
         end
      end
   endtask

   task automatic test_stall();
      applyReset8();
      for (int k = 0; k < 16; k++) cycle8(1'b1, k, 1'b0);
      nCompared++;
      if (inReady8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_in_ready got=%b exp=0", inReady8); end
      nCompared++;
      if (overflow8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_early_overflow got=%b exp=0", overflow8); end
      cycle8(1'b1, 16, 1'b0);
      nCompared++;
      if (overflow8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_overflow got=%b exp=1", overflow8); end
      for (int t = 0; t < 3; t++) cycle8(1'b0, 0, 1'b0);
      nCompared++;
      if (outValid8 !== 1'b1 || outData8.r !== 16'sd0 || outData8.i !== 16'sd0 || outLast8 !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL stall_hold got=v%b r%0d i%0d l%b exp=v1 r0 i0 l0", outValid8, outData8.r, outData8.i, outLast8);
      end
      for (int t = 0; t < 60 && gotR.size() < 16; t++) cycle8(1'b0, 0, 1'b1);
      for (int t = 0; t < 4; t++) cycle8(1'b0, 0, 1'b1);
      nCompared++;
      if (gotR.size() !== 16) begin nMismatched++; $display("[TB] FAIL stall_count got=%0d exp=16", gotR.size()); end
      for (int m = 0; m < gotR.size() && m < 16; m++) begin
         nCompared++;
         if (gotR[m] !== (m / 8) * 8 + brev8Tab[m % 8]) begin
            nMismatched++;
            $display("[TB] FAIL stall_data[%0d] got=%0d exp=%0d", m, gotR[m], (m / 8) * 8 + brev8Tab[m % 8]);
         end
      end
      nCompared++;
      if (overflow8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_sticky got=%b exp=1", overflow8); end
   endtask

   task automatic test_reset_midframe();
      clearQ();
      for (int k = 0; k < 5; k++) cycle8(1'b1, 50 + k, 1'b1);
      reset8 = 1'b1;
      cycle8(1'b0, 0, 1'b1);
      reset8 = 1'b0;
      nCompared++;
      if (outValid8 !== 1'b0 || overflow8 !== 1'b0 || inReady8 !== 1'b1 || outData8 !== '0) begin
         nMismatched++;
         $display("[TB] FAIL midreset_state got=v%b ovf%b rdy%b d%h exp=v0 ovf0 rdy1 d0", outValid8, overflow8, inReady8, outData8);
      end
      clearQ();
      for (int k = 0; k < 8; k++) cycle8(1'b1, 100 + k, 1'b1);
      for (int t = 0; t < 20; t++) cycle8(1'b0, 0, 1'b1);
      nCompared++;
      if (gotR.size() !== 8) begin nMismatched++; $display("[TB] FAIL midreset_count got=%0d exp=8", gotR.size()); end
      if (gotCyc.size() > 0) begin
         nCompared++;
         if (gotCyc[0] !== lastAccCyc + 1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_first_valid got=edge%0d exp=edge%0d", gotCyc[0], lastAccCyc + 1);
         end
      end
      for (int m = 0; m < gotR.size() && m < 8; m++) begin
         nCompared++;
         if (gotR[m] !== 100 + brev8Tab[m]) begin
            nMismatched++;
            $display("[TB] FAIL midreset_data[%0d] got=%0d exp=%0d", m, gotR[m], 100 + brev8Tab[m]);
         end
      end
      nCompared++;
      if (overflow8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_overflow got=%b exp=0", overflow8); end
   endtask

   task automatic test_toggle_ready();
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      applyReset8();
      for (int t = 0; t < 40; t++) cycle8(t < 8, 200 + t, pat[t % 4]);
      nCompared++;
      if (gotR.size() !== 8) begin nMismatched++; $display("[TB] FAIL toggle_count got=%0d exp=8", gotR.size()); end
      for (int m = 0; m < gotR.size() && m < 8; m++) begin
         nCompared++;
         if (gotR[m] !== 200 + brev8Tab[m] || gotL[m] !== (m == 7)) begin
            nMismatched++;
            $display("[TB] FAIL toggle_data[%0d] got=%0d last=%b exp=%0d last=%b", m, gotR[m], gotL[m], 200 + brev8Tab[m], m == 7);
         end
      end
   endtask

   task automatic test_random64();
      complex_product_t inQ[$];
      complex_product_t expD;
      int sent = 0;
      int outIdx = 0;
      int burstLeft = 0;
      int idx;
      logic burstRdy = 1'b1;
      reset64 = 1'b1;
      step();
      step();
      reset64 = 1'b0;
      for (int t = 0; t < 40000 && outIdx < 6400; t++) begin
         if (burstLeft == 0) begin
            burstRdy  = ($urandom_range(0, 3) != 0);
            burstLeft = $urandom_range(1, 12);
         end
         burstLeft--;
         outReady64 = burstRdy;
         inValid64  = (sent < 6400) && inReady64 && ($urandom_range(0, 7) != 0);
         inData64   = complex_product_t'($urandom);
         if (inValid64 && inReady64) begin
            inQ.push_back(inData64);
            sent++;
         end
         if (outValid64 && outReady64) begin
            idx = (outIdx / 64) * 64 + brevInt(outIdx % 64, 6);
            nCompared++;
            if (idx >= inQ.size()) begin
               nMismatched++;
               $display("[TB] FAIL rand64_early_output out#%0d needs input#%0d have=%0d", outIdx, idx, inQ.size());
            end else begin
               expD = inQ[idx];
               if (outData64 !== expD || outLast64 !== (outIdx % 64 == 63)) begin
                  nMismatched++;
                  $display("[TB] FAIL rand64_data out#%0d got=%h last=%b exp=%h last=%b", outIdx, outData64, outLast64,
                           expD, outIdx % 64 == 63);
               end
            end
            outIdx++;
         end
         step();
      end
      inValid64 = 1'b0;
      nCompared++;
      if (outIdx !== 6400) begin nMismatched++; $display("[TB] FAIL rand64_timeout got=%0d outputs exp=6400", outIdx); end
      nCompared++;
      if (overflow64 !== 1'b0) begin nMismatched++; $display("[TB] FAIL rand64_overflow got=%b exp=0", overflow64); end
   endtask

   initial begin
      reset8 = 1'b1;  inValid8 = 1'b0;  inData8 = '0;  outReady8 = 1'b0;
      reset64 = 1'b1; inValid64 = 1'b0; inData64 = '0; outReady64 = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stall();
      test_reset_midframe();
      test_toggle_ready();
      test_random64();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
